// File: rtl/u_bfly_collect.sv
// u_bfly_collect: counts ones on four butterfly bitstreams over a 2^BITWIDTH-sample window
module u_bfly_collect #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iReal0,
  input  logic                iImg0,
  input  logic                iReal1,
  input  logic                iImg1,
  input  logic                iReady,
  output logic                oBusy,
  output logic                oValid,
  output logic [BITWIDTH-1:0] oReal0,
  output logic [BITWIDTH-1:0] oImg0,
  output logic [BITWIDTH-1:0] oReal1,
  output logic [BITWIDTH-1:0] oImg1
);
  localparam int AW = BITWIDTH + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]          state, nxtState;
  logic [AW-1:0]       accReal0, accImg0, accReal1, accImg1;
  logic [AW-1:0]       nxtReal0, nxtImg0, nxtReal1, nxtImg1;
  logic [BITWIDTH-1:0] cnt;
  logic                sample, lastSample, restart;

  // A count of exactly 2^BITWIDTH does not fit the result width, so clamp it
  function automatic logic [BITWIDTH-1:0] sat(input logic [AW-1:0] v);
    return v[BITWIDTH] ? '1 : v[BITWIDTH-1:0];
  endfunction

  assign sample     = (state == ACC) && iEn;
  assign lastSample = sample && (cnt == '1);
  assign restart    = iStart && ((state == IDLE) || ((state == HOLD) && iReady));
  assign nxtReal0   = accReal0 + AW'(iReal0);
  assign nxtImg0    = accImg0 + AW'(iImg0);
  assign nxtReal1   = accReal1 + AW'(iReal1);
  assign nxtImg1    = accImg1 + AW'(iImg1);

  // Next-state decode; abort is handled in the state register
  always_comb begin
    nxtState = state;
    if ((state == IDLE) && iStart) nxtState = ACC;
    else if ((state == ACC) && lastSample) nxtState = HOLD;
    else if ((state == HOLD) && iReady) nxtState = iStart ? ACC : IDLE;
  end

  // State plus registered status flags derived from the next state
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state  <= IDLE;
      oBusy  <= 1'b0;
      oValid <= 1'b0;
    end else if (iClr) begin
      state  <= IDLE;
      oBusy  <= 1'b0;
      oValid <= 1'b0;
    end else begin
      state  <= nxtState;
      oBusy  <= nxtState == ACC;
      oValid <= nxtState == HOLD;
    end
  end

  // Accumulators and sample counter; the counter wrap marks window completion
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      accReal0 <= '0;
      accImg0  <= '0;
      accReal1 <= '0;
      accImg1  <= '0;
      cnt      <= '0;
    end else if (iClr || restart) begin
      accReal0 <= '0;
      accImg0  <= '0;
      accReal1 <= '0;
      accImg1  <= '0;
      cnt      <= '0;
    end else if (sample) begin
      accReal0 <= nxtReal0;
      accImg0  <= nxtImg0;
      accReal1 <= nxtReal1;
      accImg1  <= nxtImg1;
      cnt      <= cnt + BITWIDTH'(1);
    end
  end

  // Result registers load the final counts, including the last sample
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oReal0 <= '0;
      oImg0  <= '0;
      oReal1 <= '0;
      oImg1  <= '0;
    end else if (iClr) begin
      oReal0 <= '0;
      oImg0  <= '0;
      oReal1 <= '0;
      oImg1  <= '0;
    end else if (lastSample) begin
      oReal0 <= sat(nxtReal0);
      oImg0  <= sat(nxtImg0);
      oReal1 <= sat(nxtReal1);
      oImg1  <= sat(nxtImg1);
    end
  end
endmodule

// File: tb/tb_u_bfly_collect.sv
// tb_u_bfly_collect: directed checks of window counting, saturation, hold, abort and reset
module tb_u_bfly_collect;
  logic       iClk, iRstN, iStart, iEn, iClr, iReady;
  logic       iReal0, iImg0, iReal1, iImg1;
  logic       oBusy, oValid;
  logic [7:0] oReal0, oImg0, oReal1, oImg1;
  int         checks = 0;
  int         errors = 0;

  u_bfly_collect #(.BITWIDTH(8)) dut (
    .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iEn(iEn), .iClr(iClr),
    .iReal0(iReal0), .iImg0(iImg0), .iReal1(iReal1), .iImg1(iImg1),
    .iReady(iReady), .oBusy(oBusy), .oValid(oValid),
    .oReal0(oReal0), .oImg0(oImg0), .oReal1(oReal1), .oImg1(oImg1)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkOuts(input string tag, input int r0, input int i0, input int r1, input int i1);
    chk({tag, " real0"}, 32'(oReal0), 32'(r0));
    chk({tag, " img0"}, 32'(oImg0), 32'(i0));
    chk({tag, " real1"}, 32'(oReal1), 32'(r1));
    chk({tag, " img1"}, 32'(oImg1), 32'(i1));
  endtask

  initial begin
    iRstN = 1'b0; iStart = 1'b0; iEn = 1'b0; iClr = 1'b0; iReady = 1'b0;
    iReal0 = 1'b0; iImg0 = 1'b0; iReal1 = 1'b0; iImg1 = 1'b0;
    step(); step();
    chk("rst busy", 32'(oBusy), 0);
    chk("rst valid", 32'(oValid), 0);
    chkOuts("rst", 0, 0, 0, 0);
    @(negedge iClk) iRstN = 1'b1;
    step();
    chk("idle busy", 32'(oBusy), 0);

    // All-ones window: iStart edge counts as edge 1, oValid rises after edge 257
    iReal0 = 1; iImg0 = 1; iReal1 = 1; iImg1 = 1; iEn = 1; iStart = 1;
    step();
    iStart = 0;
    chk("ones start busy", 32'(oBusy), 1);
    chk("ones start valid", 32'(oValid), 0);
    repeat (255) step();
    chk("ones edge256 valid", 32'(oValid), 0);
    chk("ones edge256 busy", 32'(oBusy), 1);
    step();
    chk("ones edge257 valid", 32'(oValid), 1);
    chk("ones edge257 busy", 32'(oBusy), 0);
    chkOuts("ones sat", 255, 255, 255, 255);

    // HOLD with iReady low ignores iStart pulses and holds results
    iReal0 = 0; iImg0 = 0; iReal1 = 0; iImg1 = 0;
    for (int i = 0; i < 20; i++) begin
      iStart = i[0];
      step();
      chk("hold valid", 32'(oValid), 1);
      chk("hold busy", 32'(oBusy), 0);
    end
    chkOuts("hold outs", 255, 255, 255, 255);

    // iReady with iStart restarts straight into a fresh window
    iReady = 1; iStart = 1; iReal0 = 1;
    step();
    iReady = 0; iStart = 0;
    chk("restart valid", 32'(oValid), 0);
    chk("restart busy", 32'(oBusy), 1);
    chk("restart keeps real0", 32'(oReal0), 255);
    for (int i = 0; i < 256; i++) begin
      iReal0 = (i % 2 == 0);
      step();
    end
    iReal0 = 0;
    chk("alt valid", 32'(oValid), 1);
    chkOuts("alt", 128, 0, 0, 0);
    iReady = 1;
    step();
    iReady = 0;
    chk("accept valid", 32'(oValid), 0);
    chk("accept busy", 32'(oBusy), 0);
    step();
    chk("idle stays busy", 32'(oBusy), 0);

    // iEn toggling: 256 samples on odd edges, completion after 512 edges
    iImg1 = 1; iStart = 1; iEn = 0;
    step();
    iStart = 0;
    for (int k = 1; k < 511; k++) begin
      iEn = (k % 2 == 1);
      step();
      chk("toggle busy", 32'(oBusy), 1);
      chk("toggle valid", 32'(oValid), 0);
    end
    iEn = 1;
    step();
    chk("toggle done valid", 32'(oValid), 1);
    chkOuts("toggle", 0, 0, 0, 255);
    iReady = 1;
    step();
    iReady = 0;

    // Abort at sample 100 with iClr clears outputs and state
    iReal0 = 1; iImg0 = 1; iReal1 = 1; iImg1 = 1; iStart = 1;
    step();
    iStart = 0;
    repeat (99) step();
    iClr = 1;
    step();
    iClr = 0;
    chk("clr busy", 32'(oBusy), 0);
    chk("clr valid", 32'(oValid), 0);
    chkOuts("clr", 0, 0, 0, 0);
    iClr = 1; iStart = 1;
    step();
    iClr = 0; iStart = 0;
    chk("clr over start busy", 32'(oBusy), 0);
    iStart = 1;
    step();
    iStart = 0;
    for (int i = 0; i < 256; i++) begin
      iReal0 = 0;
      iImg0 = (i % 4 == 0);
      iReal1 = (i < 200);
      iImg1 = 1;
      step();
    end
    chk("fresh valid", 32'(oValid), 1);
    chkOuts("fresh", 0, 64, 200, 255);
    iReady = 1;
    step();
    iReady = 0;

    // Asynchronous reset at sample 100 discards the window
    iReal0 = 1; iImg0 = 1; iReal1 = 1; iImg1 = 1; iStart = 1;
    step();
    iStart = 0;
    repeat (99) step();
    #2 iRstN = 0;
    #1;
    chk("arst busy", 32'(oBusy), 0);
    chk("arst valid", 32'(oValid), 0);
    chkOuts("arst", 0, 0, 0, 0);
    @(negedge iClk) iRstN = 1;
    repeat (3) step();
    chk("post rst idle busy", 32'(oBusy), 0);
    chk("post rst idle valid", 32'(oValid), 0);
    iStart = 1;
    step();
    iStart = 0;
    for (int i = 0; i < 256; i++) begin
      iReal0 = (i % 2 == 1);
      step();
    end
    chk("post rst valid", 32'(oValid), 1);
    chkOuts("post rst", 128, 255, 255, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/u_bfly_collect.md
U_BFLY_COLLECT -- requirements
Module: u_bfly_collect

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: window length 2^BITWIDTH samples and width of each binary result.
REQ-002 SHALL have port iClk, input, 1: clock; all state changes on the rising edge.
REQ-003 SHALL have port iRstN, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port iStart, input, 1: request to open a new accumulation window.
REQ-005 SHALL have port iEn, input, 1: sample-enable; a window cycle counts only when iEn=1.
REQ-006 SHALL have port iClr, input, 1: synchronous abort and clear.
REQ-007 SHALL have ports iReal0, iImg0, iReal1, iImg1, input, 1 each: butterfly output bitstreams.
REQ-008 SHALL have port iReady, input, 1: consumer accepts the held result.
REQ-009 SHALL have port oBusy, output, 1: window in progress.
REQ-010 SHALL have port oValid, output, 1: results held and valid.
REQ-011 SHALL have ports oReal0, oImg0, oReal1, oImg1, output, BITWIDTH each: ones-count of the corresponding stream over the last window.

Function
REQ-012 SHALL implement three states: IDLE, ACC and HOLD.
REQ-013 IDLE: oBusy=0, oValid=0; iStart=1 SHALL move to ACC and clear the four accumulators and the sample counter on the same edge.
REQ-014 ACC: oBusy=1; on each edge with iEn=1, each accumulator SHALL add its input bit and the sample counter SHALL increment.
REQ-015 ACC with iEn=0 SHALL hold all counters unchanged.
REQ-016 iStart SHALL be ignored in ACC and in HOLD, except as stated in REQ-020.
REQ-017 Accumulators SHALL be BITWIDTH+1 bits wide, so a count of 2^BITWIDTH cannot wrap.
REQ-018 On the edge that takes the 2^BITWIDTH-th enabled sample, which includes that sample:
- state SHALL move to HOLD;
- the output registers SHALL load the final counts;
- oValid SHALL be 1 in the following cycle.
REQ-019 Each output SHALL be min(count, 2^BITWIDTH-1); an all-ones stream saturates and does not wrap to 0.
REQ-020 HOLD:
- outputs and oValid=1 SHALL remain stable while iReady=0;
- iReady=1 SHALL move to IDLE;
- iReady=1 together with iStart=1 SHALL move directly to ACC with counters cleared;
- oValid=0 in the following cycle in both cases.
REQ-021 iClr=1 in any state SHALL move to IDLE, zero the accumulators, the sample counter and all outputs, and drop oValid and oBusy; iClr SHALL take priority over iStart, iEn and iReady.
REQ-022 The sample counter SHALL be BITWIDTH bits wide and wrap to 0 on the final sample; the wrap SHALL be the window-complete condition.
REQ-023 Outputs SHALL be registered; there is no combinational path from any input to any output.

Reset
REQ-024 While iRstN=0: state SHALL be IDLE, and all accumulators, the sample counter, oReal0/oImg0/oReal1/oImg1, oValid and oBusy SHALL be 0.
REQ-025 Reset asserted mid-window SHALL discard partial counts; after release the block SHALL wait in IDLE for iStart.

Verification
REQ-026 All four inputs held at 1, iEn=1, BITWIDTH=8, single iStart pulse -> oValid rises exactly 257 cycles after the iStart edge; all outputs 255 (saturated).
REQ-027 iReal0 alternating 1,0 from the first sample, all other inputs 0 -> oReal0=128, others 0.
REQ-028 iEn toggling 1,0 every cycle, iImg1=1 -> window completes after 512 cycles; oImg1=255; oBusy=1 for the whole window.
REQ-029 HOLD with iReady=0 for 20 cycles and iStart pulses -> outputs and oValid unchanged; then iReady=1 and iStart=1 on the same cycle -> oValid falls, oBusy rises, counts restart from 0.
REQ-030 iClr=1 at sample 100, and separately iRstN=0 at sample 100 -> oBusy=0, all outputs 0; a later iStart produces a full fresh 256-sample window with correct counts.
